nvme_mmio_wr_arb: RTL

//  Round-robin arbiter that shares the single PCIe MMIO write port (wrvalid/wraddr/wrdata/wrack)

---
 rtl/nvme_mmio_wr_arb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/nvme_mmio_wr_arb.sv
// Round-robin arbiter that shares one PCIe MMIO write port between num_req requesters.
// The winner is registered, held until pcie_wrack, and the ack is routed back one-hot.
module nvme_mmio_wr_arb #(
    parameter int unsigned num_req    = 4,
    parameter int unsigned addr_width = 32,
    parameter int unsigned data_width = 16,
    parameter int unsigned tmo_width  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            arb_hold,
    input  logic [num_req-1:0]              req_wrvalid,
    input  logic [num_req*addr_width-1:0]   req_wraddr,
    input  logic [num_req*data_width-1:0]   req_wrdata,
    output logic [num_req-1:0]              req_wrack,
    output logic                            pcie_wrvalid,
    output logic [addr_width-1:0]           pcie_wraddr,
    output logic [data_width-1:0]           pcie_wrdata,
    input  logic                            pcie_wrack,
    input  logic [tmo_width-1:0]            tmo_limit,
    input  logic                            tmo_clr,
    output logic                            arb_timeout,
    output logic                            arb_busy,
    output logic [$clog2(num_req)-1:0]      arb_grant_id
);

    localparam int unsigned gid_width = $clog2(num_req);
    localparam int unsigned sum_width = gid_width + 1;

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e                 state_q;
    logic [gid_width-1:0]   rr_ptr_q;
    logic [tmo_width-1:0]   tmo_cnt_q;

    logic                   win_valid;
    logic [gid_width-1:0]   win_id;
    logic [addr_width-1:0]  win_addr;
    logic [data_width-1:0]  win_data;
    logic                   ack_fire;
    logic                   tmo_hit;

    // (base + offs) mod num_req, computed one bit wider so non-power-of-2 counts wrap correctly
    function automatic logic [gid_width-1:0] rr_index(input logic [gid_width-1:0] base,
                                                      input int unsigned offs);
        logic [sum_width-1:0] sum;
        sum = {1'b0, base} + sum_width'(offs);
        if (sum >= sum_width'(num_req)) begin
            sum = sum - sum_width'(num_req);
        end
        return sum[gid_width-1:0];
    endfunction

    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int unsigned k = 0; k < num_req; k++) begin
            if (!win_valid && req_wrvalid[rr_index(rr_ptr_q, k)]) begin
                win_valid = 1'b1;
                win_id    = rr_index(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            if (win_id == gid_width'(i)) begin
                win_addr = req_wraddr[i*addr_width +: addr_width];
                win_data = req_wrdata[i*data_width +: data_width];
            end
        end
    end

    // A write caught by reset is dropped, so no ack is routed back in the reset cycle
    assign ack_fire = (state_q == StIssue) && pcie_wrack && !reset;

    always_comb begin
        req_wrack = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            req_wrack[i] = ack_fire && (arb_grant_id == gid_width'(i));
        end
    end

    assign tmo_hit = (state_q == StIssue) && !pcie_wrack && (tmo_limit != '0) &&
                     (tmo_cnt_q == tmo_limit - tmo_width'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            tmo_cnt_q    <= '0;
            pcie_wrvalid <= 1'b0;
            pcie_wraddr  <= '0;
            pcie_wrdata  <= '0;
            arb_timeout  <= 1'b0;
            arb_busy     <= 1'b0;
            arb_grant_id <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!arb_hold && win_valid) begin
                        pcie_wraddr  <= win_addr;
                        pcie_wrdata  <= win_data;
                        arb_grant_id <= win_id;
                        tmo_cnt_q    <= '0;
                        pcie_wrvalid <= 1'b1;
                        arb_busy     <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    if (pcie_wrack) begin
                        rr_ptr_q     <= rr_index(arb_grant_id, 1);
                        pcie_wrvalid <= 1'b0;
                        arb_busy     <= 1'b0;
                        state_q      <= StIdle;
                    end else if (tmo_cnt_q != {tmo_width{1'b1}}) begin
                        tmo_cnt_q <= tmo_cnt_q + tmo_width'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Timeout is sticky; a set in the same cycle beats a clear
            if (tmo_hit) begin
                arb_timeout <= 1'b1;
            end else if (tmo_clr) begin
                arb_timeout <= 1'b0;
            end
        end
    end

endmodule
